// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data_memory port between the core load/store path
//   (port C) and a debug/loader engine (port D). Grants are decided
//   combinationally each cycle. The winning request is driven onto m_*.
//   Read responses are steered back to their owner READ_LAT cycles later.
//   Any core request that is not granted raises core_stall, and those stall
//   cycles are counted in a saturating counter.
//
//   Build option: define DMEM_ARB_RR_EN for round-robin resolution of
//   contention. When it is undefined, C has fixed priority over D.
//   Debug lock (exclusive D ownership) behaves the same in both builds.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata core request in
//   c_gnt/c_rvalid/c_rdata   core grant and read response out
//   d_req/d_we/d_addr/d_wdata debug request in
//   d_lock                   debug asks for exclusive ownership
//   d_gnt/d_rvalid/d_rdata   debug grant and read response out
//   m_memread/m_memwrite/m_addr/m_wdata  to data_memory
//   m_rdata                  from data_memory
//   core_stall               c_req & ~c_gnt
//   stall_cnt                saturating count of core_stall cycles
// -----------------------------------------------------------------------------
//   state   | meaning
//   ST_ARB  | normal arbitration between C and D every cycle
//   ST_LOCK | D owns the port exclusively while d_lock stays high
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int READ_LAT = 1,   // legal range 1..4
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [AW-1:0]    c_addr,
    input  logic [DW-1:0]    c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [DW-1:0]    c_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    input  logic             d_lock,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DW-1:0]    d_rdata,
    output logic             m_memread,
    output logic             m_memwrite,
    output logic [AW-1:0]    m_addr,
    output logic [DW-1:0]    m_wdata,
    input  logic [DW-1:0]    m_rdata,
    output logic             core_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t              state;
    logic                locked;
    logic                gnt_c;
    logic                gnt_d;
    logic                gnt_we;
    logic [READ_LAT-1:0] tag_v;   // read in flight
    logic [READ_LAT-1:0] tag_d;   // owner of that read: 1 = D, 0 = C

`ifdef DMEM_ARB_RR_EN
    logic                last_d;  // owner of the most recent grant: 1 = D
`endif

    // The lock only holds while d_lock stays high, so the cycle that drops
    // d_lock already arbitrates normally.
    assign locked = (state == ST_LOCK) && d_lock;

    // Grants are gated by reset so nothing reaches memory while held in reset.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (rst) begin
            if (locked) begin
                gnt_d = d_req;
            end else if (c_req && d_req) begin
`ifdef DMEM_ARB_RR_EN
                gnt_c = last_d;
                gnt_d = ~last_d;
`else
                gnt_c = 1'b1;
`endif
            end else begin
                gnt_c = c_req;
                gnt_d = d_req;
            end
        end
    end

    assign c_gnt      = gnt_c;
    assign d_gnt      = gnt_d;
    assign gnt_we     = gnt_c ? c_we : (gnt_d ? d_we : 1'b0);
    assign m_memread  = (gnt_c | gnt_d) & ~gnt_we;
    assign m_memwrite = (gnt_c | gnt_d) & gnt_we;
    assign m_addr     = gnt_c ? c_addr  : (gnt_d ? d_addr  : '0);
    assign m_wdata    = gnt_c ? c_wdata : (gnt_d ? d_wdata : '0);
    assign core_stall = c_req & ~gnt_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ARB;
        end else begin
            case (state)
                ST_ARB:  if (gnt_d && d_lock) state <= ST_LOCK;
                ST_LOCK: if (!d_lock && !(gnt_d && d_lock)) state <= ST_ARB;
                default: state <= ST_ARB;
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b1;
        end else if (gnt_c) begin
            last_d <= 1'b0;
        end else if (gnt_d) begin
            last_d <= 1'b1;
        end
    end
`endif

    // Each read drops a tag in at stage 0. The response is valid when the
    // tag reaches the last stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v <= '0;
            tag_d <= '0;
        end else begin
            tag_v[0] <= m_memread;
            tag_d[0] <= gnt_d;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_d[i] <= tag_d[i-1];
            end
        end
    end

    assign c_rvalid = tag_v[READ_LAT-1] & ~tag_d[READ_LAT-1];
    assign d_rvalid = tag_v[READ_LAT-1] &  tag_d[READ_LAT-1];
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (core_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
